// File: rtl/mult_datapath.sv
// Datapath for the sequential 8x8 signed multiplier.
// Operands arrive byte-serially on inbus; control strobes c0..c8 come from the
// multiplier controller, which branches on s and is_count_7. The product
// leaves byte-serially on outbus, high byte (A) first, then low byte (Q).
//
// {F,A} is a 9-bit signed accumulator. Eight add-and-shift iterations treat Q
// as unsigned. After the 8th shift D is set; the adder then subtracts, so a
// final c3 removes M*256 when the multiplier was negative (QS=1).

module mult_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] inbus,
  input  logic             c0,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             c4,
  input  logic             c5,
  input  logic             c6,
  input  logic             c7,
  input  logic             c8,
  output logic             s,
  output logic             is_count_7,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid
);

  // State registers
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  // acc_q = {F, A}: MSB is the sign-extension bit F
  logic [WIDTH:0]   acc_q, acc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             qs_q, qs_d;
  logic             d_q, d_d;
  logic [WIDTH-1:0] outbus_q, outbus_d;
  logic             out_valid_q, out_valid_d;

  // Adder and shifter intermediates
  logic [WIDTH:0]   add_op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   acc_shifted;
  logic [WIDTH-1:0] q_shifted;

  // 9-bit adder: adds during iterations, subtracts once D marks the correction step
  always_comb begin
    add_op  = c4 ? '0 : {m_q[WIDTH-1], m_q};
    add_sum = d_q ? (acc_q - add_op) : (acc_q + add_op);
  end

  // Arithmetic right shift of {F,A,Q}: F is replicated, A[0] falls into Q[7]
  always_comb begin
    acc_shifted = {acc_q[WIDTH], acc_q[WIDTH:1]};
    q_shifted   = {acc_q[0], q_q[WIDTH-1:1]};
  end

  // Multiplicand load
  always_comb begin
    m_d = m_q;
    if (c0) begin
      m_d = inbus;
    end
  end

  // Multiplier load and sign capture; a load takes priority over a shift of Q
  always_comb begin
    q_d  = q_q;
    qs_d = qs_q;
    if (c1) begin
      q_d  = inbus;
      qs_d = inbus[WIDTH-1];
    end else if (c5) begin
      q_d = q_shifted;
    end
  end

  // Accumulator: clear beats add, add beats shift
  always_comb begin
    acc_d = acc_q;
    if (c2) begin
      acc_d = '0;
    end else if (c3) begin
      acc_d = add_sum;
    end else if (c5) begin
      acc_d = acc_shifted;
    end
  end

  // Iteration counter, wraps 7 -> 0
  always_comb begin
    cnt_d = cnt_q;
    if (c2) begin
      cnt_d = '0;
    end else if (c6) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Loop-done flag: set by the shift taken while cnt==7 (the 8th shift)
  always_comb begin
    d_d = d_q;
    if (c2) begin
      d_d = 1'b0;
    end else if (c5 && (cnt_q == 3'd7)) begin
      d_d = 1'b1;
    end
  end

  // Output byte register; low byte wins if both strobes coincide
  always_comb begin
    outbus_d    = outbus_q;
    out_valid_d = c7 | c8;
    if (c8) begin
      outbus_d = q_q;
    end else if (c7) begin
      outbus_d = acc_q[WIDTH-1:0];
    end
  end

  // Operand registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_q  <= '0;
      q_q  <= '0;
      qs_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      q_q  <= q_d;
      qs_q <= qs_d;
    end
  end

  // Accumulator and loop control registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_q <= '0;
      cnt_q <= '0;
      d_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      d_q   <= d_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      outbus_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      outbus_q    <= outbus_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Status back to the controller, from registers only
  always_comb begin
    s          = d_q ? qs_q : q_q[0];
    is_count_7 = (cnt_q == 3'd7);
    outbus     = outbus_q;
    out_valid  = out_valid_q;
  end

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: emulates the controller and checks
// the product against plain signed multiplication.

module tb_mult_datapath;

  localparam logic [8:0] C0 = 9'h001;
  localparam logic [8:0] C1 = 9'h002;
  localparam logic [8:0] C2 = 9'h004;
  localparam logic [8:0] C3 = 9'h008;
  localparam logic [8:0] C4 = 9'h010;
  localparam logic [8:0] C5 = 9'h020;
  localparam logic [8:0] C6 = 9'h040;
  localparam logic [8:0] C7 = 9'h080;
  localparam logic [8:0] C8 = 9'h100;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] inbus = 8'h00;
  logic [8:0] ctrl = 9'h000;
  logic       s;
  logic       is_count_7;
  logic [7:0] outbus;
  logic       out_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_datapath #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .inbus      (inbus),
    .c0         (ctrl[0]),
    .c1         (ctrl[1]),
    .c2         (ctrl[2]),
    .c3         (ctrl[3]),
    .c4         (ctrl[4]),
    .c5         (ctrl[5]),
    .c6         (ctrl[6]),
    .c7         (ctrl[7]),
    .c8         (ctrl[8]),
    .s          (s),
    .is_count_7 (is_count_7),
    .outbus     (outbus),
    .out_valid  (out_valid)
  );

  // Hold strobes for one rising edge; return 1 time unit after it
  task automatic pulse(input logic [8:0] strobes, input logic [7:0] data);
    ctrl  = strobes;
    inbus = data;
    @(posedge clk);
    #1;
    ctrl  = 9'h000;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #3;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Full controller sequence with product and status checks
  task automatic run_mult(input logic [7:0] m, input logic [7:0] q, input string name);
    int         prod;
    logic [15:0] p;
    prod = int'($signed(m)) * int'($signed(q));
    p    = prod[15:0];
    pulse(C0, m);
    pulse(C1, q);
    pulse(C2, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (s !== q[i]) begin
        fails++;
        $display("FAIL %s s_iter%0d: got %b expected %b", name, i, s, q[i]);
      end
      tests++;
      if (is_count_7 !== (i == 7)) begin
        fails++;
        $display("FAIL %s cnt7_iter%0d: got %b expected %b", name, i, is_count_7, i == 7);
      end
      pulse(q[i] ? C3 : (C3 | C4), 8'h00);
      pulse(C5, 8'h00);
      pulse(C6, 8'h00);
    end
    tests++;
    if (s !== q[7]) begin
      fails++;
      $display("FAIL %s s_after_loop: got %b expected %b", name, s, q[7]);
    end
    if (q[7]) pulse(C3, 8'h00);
    pulse(C7, 8'h00);
    tests++;
    if (outbus !== p[15:8] || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s high_byte: got %h/v%b expected %h/v1", name, outbus, out_valid,
               p[15:8]);
    end
    pulse(9'h000, 8'h00);
    tests++;
    if (out_valid !== 1'b0 || outbus !== p[15:8]) begin
      fails++;
      $display("FAIL %s hold_high: got %h/v%b expected %h/v0", name, outbus, out_valid,
               p[15:8]);
    end
    pulse(C8, 8'h00);
    tests++;
    if (outbus !== p[7:0] || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s low_byte: got %h/v%b expected %h/v1", name, outbus, out_valid, p[7:0]);
    end
    pulse(9'h000, 8'h00);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s valid_drop: got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    #7;
    tests++;
    if ({s, is_count_7, outbus, out_valid} !== 11'h000) begin
      fails++;
      $display("FAIL reset_state: got s%b c%b o%h v%b expected all zero", s, is_count_7,
               outbus, out_valid);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    run_mult(8'h05, 8'h03, "5x3");
    run_mult(8'hFD, 8'h04, "m3x4");
    run_mult(8'h07, 8'hFE, "7xm2");
    run_mult(8'h80, 8'h80, "m128xm128");
    run_mult(8'h7F, 8'h80, "127xm128");
    run_mult(8'h00, 8'hFF, "0xm1");
  endtask

  task automatic test_random();
    logic [7:0] m;
    logic [7:0] q;
    for (int k = 0; k < 30; k++) begin
      m = 8'($urandom);
      q = 8'($urandom);
      run_mult(m, q, "random");
    end
  endtask

  task automatic test_counter();
    do_reset();
    // Q=0x01, QS=0: s stays 1 only while D remains clear
    pulse(C1, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      pulse(C6, 8'h00);
      tests++;
      if (is_count_7 !== (k == 7)) begin
        fails++;
        $display("FAIL counter_pulse%0d: got %b expected %b", k, is_count_7, k == 7);
      end
    end
    tests++;
    if (s !== 1'b1) begin
      fails++;
      $display("FAIL counter_d_clear: got s=%b expected 1", s);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse(C0, 8'h05);
    pulse(C1, 8'h03);
    pulse(C2, 8'h00);
    pulse(C7, 8'h00);
    for (int i = 0; i < 4; i++) begin
      pulse(C3, 8'h00);
      if (i == 3) break;
      pulse(C5, 8'h00);
      pulse(C6, 8'h00);
    end
    // Mid-cycle, away from any edge: reset must take effect without a clock
    #2;
    rst_b = 1'b0;
    #1;
    tests++;
    if ({s, is_count_7, outbus, out_valid} !== 11'h000) begin
      fails++;
      $display("FAIL reset_mid: got s%b c%b o%h v%b expected all zero", s, is_count_7,
               outbus, out_valid);
    end
    // out_valid drop: pulse c7 then reset before the next edge
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    pulse(C7, 8'h00);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL valid_before_reset: got %b expected 1", out_valid);
    end
    #2;
    rst_b = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_async_drop: got %b expected 0", out_valid);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    run_mult(8'h05, 8'h03, "5x3_after_reset");
  endtask

  task automatic test_precedence();
    do_reset();
    pulse(C0, 8'h33);
    pulse(C1, 8'h5A);
    // c7 and c8 together: low byte (Q) is driven
    pulse(C7 | C8, 8'h00);
    tests++;
    if (outbus !== 8'h5A) begin
      fails++;
      $display("FAIL prec_c8_over_c7: got %h expected 5a", outbus);
    end
    // add M then try add+clear together: clear wins
    pulse(C3, 8'h00);
    pulse(C2 | C3, 8'h00);
    pulse(C7, 8'h00);
    tests++;
    if (outbus !== 8'h00) begin
      fails++;
      $display("FAIL prec_c2_over_c3: got %h expected 00", outbus);
    end
    // add with shift: A gets the sum, Q still shifts in old A[0]=0
    pulse(C3 | C5, 8'h00);
    pulse(C7, 8'h00);
    tests++;
    if (outbus !== 8'h33) begin
      fails++;
      $display("FAIL prec_c3_over_c5_a: got %h expected 33", outbus);
    end
    pulse(C8, 8'h00);
    tests++;
    if (outbus !== 8'h2D) begin
      fails++;
      $display("FAIL prec_c3_over_c5_q: got %h expected 2d", outbus);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_counter();
    test_reset_mid();
    test_precedence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Datapath for the sequential 8x8 signed (two's-complement) multiplier. It sits directly downstream of the multiplier control unit: it consumes the one-hot control strobes c0..c8 and returns the status bits s and is_count_7 that steer the controller's branches. The operands arrive byte-serially on inbus, and the 16-bit product leaves byte-serially on outbus, high byte first.

## Interface
- WIDTH, 8, operand width in bits; the only supported value is 8, and the counter is fixed at 3 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- inbus  in  8  operand input, sampled on c0 (multiplicand M) and c1 (multiplier Q).
- c0  in  1  load M from inbus.
- c1  in  1  load Q from inbus; capture QS = inbus[7].
- c2  in  1  clear A, F, cnt, D.
- c3  in  1  write adder result into {F,A}.
- c4  in  1  adder operand select: 1 selects zero, 0 selects M.
- c5  in  1  arithmetic right shift of {F,A,Q}.
- c6  in  1  increment iteration counter cnt.
- c7  in  1  drive A onto outbus (high byte).
- c8  in  1  drive Q onto outbus (low byte).
- s  out  1  branch status: Q[0] while D=0, QS once D=1.
- is_count_7  out  1  cnt == 7.
- outbus  out  8  registered product byte.
- out_valid  out  1  high for exactly one cycle after each c7 or c8.

## Operation
- Registers:
  - M[7:0], Q[7:0], A[7:0].
  - F (sign-extension bit of A), which makes {F,A} a 9-bit signed accumulator.
  - cnt[2:0]; QS (multiplier sign); D (loop-done flag); outbus; out_valid.
- Adder (9-bit signed):
  - sum = {F,A} + op when D=0; sum = {F,A} - op when D=1 (correction step).
  - op = 0 when c4=1, otherwise M sign-extended to 9 bits.
  - Wrap modulo 2^9; no overflow flag.
- On c3: {F,A} <= sum.
- On c5: {F,A,Q} <= {F, F, A, Q[7:1]} (F is replicated). If cnt==7 at that edge, D <= 1.
- On c6: cnt <= cnt+1, wrapping from 7 to 0. D is unaffected.
- On c2: A, F, cnt, D <= 0.
- On c0: M <= inbus.
- On c1: Q <= inbus and QS <= inbus[7].
- On c7: outbus <= A. On c8: outbus <= Q. In both cases out_valid <= 1 on the next edge; otherwise out_valid <= 0. outbus holds its value between strobes.
- Algorithm: eight add-and-shift iterations treat Q as unsigned, giving {A,Q} = M*Qunsigned. The final step subtracts M from {F,A} when QS=1, which yields the signed product in {A,Q}.
- Precedence when strobes coincide (the controller never does this, but behaviour must still be defined):
  - c2 overrides c3 and c5 on A, F, cnt and D.
  - c3 overrides c5 on {F,A}; Q still shifts if c5 is asserted.
  - c8 overrides c7.
  - c0, c1 and c6 act independently.
- s and is_count_7 are combinational from registers only; there is no path from the c-inputs to them.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): every register is 0, so s=0, is_count_7=0, outbus=0x00, out_valid=0.
- Every strobe takes effect at the rising edge on which it is sampled high. s and is_count_7 reflect the new state in the following cycle, in time for the controller's next branch decision.
- Output latency: outbus and out_valid update one cycle after the c7/c8 edge.
- Reset mid-operation: all state clears immediately. A partially accumulated product is discarded, and out_valid drops asynchronously.
- The D flag sets on the shift where cnt==7, i.e. the 8th shift. From then on s reports QS so the controller can branch into the correction step. D stays set until the next c2 or reset.

## Test plan
- 5 x 3: inbus 0x05 on c0, 0x03 on c1, full controller sequence -> outbus 0x00 then 0x0F, with out_valid pulsed once per byte.
- -3 x 4 (M=0xFD, Q=0x04; QS=0, so no correction) -> outbus 0xFF then 0xF4.
- 7 x -2 (M=0x07, Q=0xFE; correction step taken) -> outbus 0xFF then 0xF2; s=1 observed in the cycle after the 8th shift.
- -128 x -128 (0x80 x 0x80) -> outbus 0x40 then 0x00. This checks that the 9-bit accumulator does not overflow during correction.
- Counter boundary: 8 c6 pulses from reset -> is_count_7 high only after the 7th pulse; cnt=0 after the 8th; D remains 0 with no c5.
- Reset during iteration 4 (after the c3 edge) -> outbus=0x00, out_valid=0, s=0, is_count_7=0 immediately. A subsequent clean 5 x 3 run yields 0x00 / 0x0F.
